// File: rtl/ddr_bank_cmd_tracker.sv
// ddr_bank_cmd_tracker: decodes DDR command pins and tracks per-bank state, open row and row-close sync.
// Define DDR4_EN for bank groups (bg port) and act_n-based ACT decode; the default build is DDR3.
module ddr_bank_cmd_tracker #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int ADDRWIDTH = 17,
  parameter int T_ACT = 3,
  parameter int T_BURST = 4,
  parameter int T_PRE = 3,
`ifdef DDR4_EN
  localparam int NBG = 2**BGWIDTH,
`else
  localparam int NBG = 1,
`endif
  localparam int NB = 2**BAWIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
`ifdef DDR4_EN
  input  logic [BGWIDTH-1:0]   bg,
`endif
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 stall,
  output logic [4:0]           BankFSM [NBG][NB],
  output logic [ADDRWIDTH-1:0] RowId [NBG][NB],
  output logic                 sync [NBG][NB],
  output logic                 cmd_err
);
  typedef enum logic [4:0] {
    IDLE        = 5'b00000,
    ACTIVATING  = 5'b00011,
    ACTIVE      = 5'b00100,
    READING     = 5'b01011,
    WRITING     = 5'b10010,
    PRECHARGING = 5'b00101
  } state_t;
  localparam int TMAX = T_ACT > T_BURST ? (T_ACT > T_PRE ? T_ACT : T_PRE) : (T_BURST > T_PRE ? T_BURST : T_PRE);
  localparam int TW = $clog2(TMAX + 1);
  logic act_c, rd_c, wr_c, pre_c;
  logic [BGWIDTH-1:0] grp;
  logic [NBG*NB-1:0] err;
`ifdef DDR4_EN
  assign grp   = bg;
  assign act_c = !cs_n && !act_n;
  assign rd_c  = !cs_n && act_n && ras_n && !cas_n && we_n;
  assign wr_c  = !cs_n && act_n && ras_n && !cas_n && !we_n;
  assign pre_c = !cs_n && act_n && !ras_n && cas_n && !we_n;
`else
  wire unused = act_n;
  assign grp   = '0;
  assign act_c = !cs_n && !ras_n && cas_n && we_n;
  assign rd_c  = !cs_n && ras_n && !cas_n && we_n;
  assign wr_c  = !cs_n && ras_n && !cas_n && !we_n;
  assign pre_c = !cs_n && !ras_n && cas_n && !we_n;
`endif
  for (genvar g = 0; g < NBG; g++) begin : grp_g
    for (genvar b = 0; b < NB; b++) begin : bank_b
      state_t st, nst;
      logic [TW-1:0] tmr, ntmr;
      logic ap, nap, sy, e;
      logic [ADDRWIDTH-1:0] row;
      wire hit = grp == BGWIDTH'(g) && ba == BAWIDTH'(b);
      wire a = act_c && hit;
      wire rw = (rd_c || wr_c) && hit;
      wire pt = pre_c && (addr[10] || hit);
      wire done = tmr == TW'(1);
      // Commands are judged against the current state, so one landing on a timer expiry is illegal.
      always_comb begin
        nst = st;
        ntmr = tmr;
        nap = ap;
        e = 1'b0;
        if (!stall && st == IDLE) begin
          e = rw;
          if (a) begin nst = ACTIVATING; ntmr = TW'(T_ACT); end
        end else if (!stall && st == ACTIVE) begin
          e = a;
          if (rw) begin nst = rd_c ? READING : WRITING; ntmr = TW'(T_BURST); nap = addr[10]; end
          else if (pt) begin nst = PRECHARGING; ntmr = TW'(T_PRE); end
        end else if (!stall) begin
          e = a || rw || pt;
          ntmr = done ? '0 : tmr - TW'(1);
          if (done && (st == READING || st == WRITING) && ap) begin nst = PRECHARGING; ntmr = TW'(T_PRE); end
          else if (done) nst = st == PRECHARGING ? IDLE : ACTIVE;
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          st <= IDLE;
          tmr <= '0;
          ap <= 1'b0;
          sy <= 1'b0;
          row <= '0;
        end else begin
          st <= nst;
          tmr <= ntmr;
          ap <= nap;
          sy <= nst == PRECHARGING && st != PRECHARGING;
          if (st == IDLE && nst == ACTIVATING) row <= addr;
        end
      end
      assign err[g*NB+b] = e;
      assign BankFSM[g][b] = st;
      assign RowId[g][b] = row;
      assign sync[g][b] = sy;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) cmd_err <= 1'b0;
    else cmd_err <= stall ? (act_c || rd_c || wr_c || pre_c) : |err;
  end
endmodule

// File: tb/tb_ddr_bank_cmd_tracker.sv
// tb_ddr_bank_cmd_tracker: directed vector table plus randomized traffic against a deadline-based bank model.
module tb_ddr_bank_cmd_tracker;
`ifdef DDR4_EN
  localparam int NBG = 4;
`else
  localparam int NBG = 1;
`endif
  localparam int NB = 4, AW = 17, T_ACT = 3, T_BURST = 4, T_PRE = 3;
  localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, OTH = 5;
  localparam logic [4:0] S_I = 5'b00000, S_AG = 5'b00011, S_AC = 5'b00100,
                         S_RD = 5'b01011, S_WR = 5'b10010, S_PR = 5'b00101;

  typedef struct {
    bit rst; bit stl; int cmd; int g; int b; int addr;
    int wg; int wb; logic [4:0] est; int erow; bit esync; bit eerr;
  } vec_t;

  logic clk = 0, reset = 1, cs_n = 1, act_n = 1, ras_n = 1, cas_n = 1, we_n = 1, stall = 0;
`ifdef DDR4_EN
  logic [1:0] bg = 0;
`endif
  logic [1:0] ba = 0;
  logic [AW-1:0] addr = 0;
  logic [4:0] fsm [NBG][NB];
  logic [AW-1:0] row [NBG][NB];
  logic sync [NBG][NB];
  logic cmd_err;
  int checks = 0, errors = 0;

  logic [4:0] mst [NBG][NB];
  int mrow [NBG][NB], mdl [NBG][NB];
  bit map_ [NBG][NB], msy [NBG][NB], merr;
  int acnt;
  vec_t tbl [$];

  ddr_bank_cmd_tracker dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
`ifdef DDR4_EN
    .bg(bg),
`endif
    .ba(ba), .addr(addr), .stall(stall),
    .BankFSM(fsm), .RowId(row), .sync(sync), .cmd_err(cmd_err)
  );

  initial forever #5 clk = ~clk;

  function automatic int gmap(input int g);
    return NBG > 1 ? g : 0;
  endfunction

  task automatic add(input bit r, input bit s, input int c, input int g, input int b, input int a,
                     input int wg, input int wb, input logic [4:0] est, input int erow, input bit esy, input bit eer);
    vec_t v;
    v = '{r, s, c, g, b, a, wg, wb, est, erow, esy, eer};
    tbl.push_back(v);
  endtask

  task automatic drive(input bit r, input bit s, input int c, input int g, input int b, input int a);
    reset = r;
    stall = s;
    ba = b[1:0];
    addr = AW'(a);
`ifdef DDR4_EN
    bg = g[1:0];
`endif
    {act_n, ras_n, cas_n, we_n} = 4'($urandom);
    cs_n = c == NOP;
    case (c)
`ifdef DDR4_EN
      ACT: act_n = 1'b0;
`else
      ACT: {ras_n, cas_n, we_n} = 3'b011;
`endif
      RD:  {act_n, ras_n, cas_n, we_n} = 4'b1101;
      WR:  {act_n, ras_n, cas_n, we_n} = 4'b1100;
      PRE: {act_n, ras_n, cas_n, we_n} = 4'b1010;
      OTH: {act_n, ras_n, cas_n} = 3'b100;
      default: ;
    endcase
  endtask

  // Each timed phase ends when the count of unstalled edges reaches its deadline.
  task automatic model(input bit r, input bit s, input int c, input int g, input int b, input int a);
    bit hit, ca, crw, cp;
    if (r) begin
      acnt = 0;
      merr = 0;
      foreach (mst[i, j]) begin mst[i][j] = S_I; mrow[i][j] = 0; msy[i][j] = 0; map_[i][j] = 0; end
    end else if (s) begin
      merr = c inside {ACT, RD, WR, PRE};
      foreach (msy[i, j]) msy[i][j] = 0;
    end else begin
      acnt++;
      merr = 0;
      foreach (mst[i, j]) begin
        hit = i == gmap(g) && j == b;
        ca = c == ACT && hit;
        crw = (c == RD || c == WR) && hit;
        cp = c == PRE && (a[10] || hit);
        msy[i][j] = 0;
        if (mst[i][j] == S_I) begin
          if (crw) merr = 1;
          if (ca) begin mst[i][j] = S_AG; mdl[i][j] = acnt + T_ACT; mrow[i][j] = a; end
        end else if (mst[i][j] == S_AC) begin
          if (ca) merr = 1;
          else if (crw) begin mst[i][j] = c == RD ? S_RD : S_WR; mdl[i][j] = acnt + T_BURST; map_[i][j] = a[10]; end
          else if (cp) begin mst[i][j] = S_PR; mdl[i][j] = acnt + T_PRE; msy[i][j] = 1; end
        end else begin
          if (ca || crw || cp) merr = 1;
          if (acnt == mdl[i][j]) begin
            if (mst[i][j] == S_AG) mst[i][j] = S_AC;
            else if (mst[i][j] == S_PR) mst[i][j] = S_I;
            else if (map_[i][j]) begin mst[i][j] = S_PR; mdl[i][j] = acnt + T_PRE; msy[i][j] = 1; end
            else mst[i][j] = S_AC;
          end
        end
      end
    end
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_all();
    foreach (mst[i, j]) begin
      check($sformatf("state[%0d][%0d]", i, j), 32'(fsm[i][j]), 32'(mst[i][j]));
      check($sformatf("row[%0d][%0d]", i, j), 32'(row[i][j]), mrow[i][j]);
      check($sformatf("sync[%0d][%0d]", i, j), 32'(sync[i][j]), 32'(msy[i][j]));
    end
    check("cmd_err", 32'(cmd_err), 32'(merr));
  endtask

  task automatic step(input bit r, input bit s, input int c, input int g, input int b, input int a);
    drive(r, s, c, g, b, a);
    @(posedge clk);
    model(r, s, c, g, b, a);
    #1;
    check_all();
  endtask

  initial begin
    int wg, c, p;
    add(1,0,NOP,0,0,0,      1,2,S_I,0,0,0);
    add(0,0,ACT,1,2,'h1A2B3,1,2,S_AG,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AC,'h1A2B3,0,0);
    add(0,0,WR,1,2,0,       1,2,S_WR,'h1A2B3,0,0);
    for (int i = 0; i < 3; i++) add(0,0,NOP,0,0,0,1,2,S_WR,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AC,'h1A2B3,0,0);
    add(0,0,RD,1,2,'h400,   1,2,S_RD,'h1A2B3,0,0);
    for (int i = 0; i < 3; i++) add(0,0,NOP,0,0,0,1,2,S_RD,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_PR,'h1A2B3,1,0);
    add(0,0,NOP,0,0,0,      1,2,S_PR,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_PR,'h1A2B3,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_I,'h1A2B3,0,0);
    add(0,0,ACT,1,2,'h777,  1,2,S_AG,'h777,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'h777,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'h777,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AC,'h777,0,0);
    add(0,0,RD,0,0,0,       0,0,S_I,0,0,1);
    add(0,0,ACT,1,2,'h12345,1,2,S_AC,'h777,0,1);
    add(0,0,NOP,0,0,0,      1,2,S_AC,'h777,0,0);
    add(0,0,ACT,0,0,'h10,   0,0,S_AG,'h10,0,0);
    add(0,0,ACT,3,3,'h33,   3,3,S_AG,'h33,0,0);
    add(0,0,ACT,2,1,'h21,   2,1,S_AG,'h21,0,0);
    add(0,0,NOP,0,0,0,      0,0,S_AC,'h10,0,0);
    add(0,0,NOP,0,0,0,      3,3,S_AC,'h33,0,0);
    add(0,0,NOP,0,0,0,      2,1,S_AC,'h21,0,0);
    add(0,0,WR,2,1,0,       2,1,S_WR,'h21,0,0);
    add(0,0,PRE,0,0,'h400,  0,0,S_PR,'h10,1,1);
    add(0,0,NOP,0,0,0,      3,3,S_PR,'h33,0,0);
    add(0,0,NOP,0,0,0,      2,1,S_WR,'h21,0,0);
    add(0,0,NOP,0,0,0,      2,1,S_AC,'h21,0,0);
    add(0,0,PRE,2,1,0,      2,1,S_PR,'h21,1,0);
    add(0,0,NOP,0,0,0,      0,0,S_I,'h10,0,0);
    add(0,0,ACT,1,2,'hABC,  1,2,S_AG,'hABC,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'hABC,0,0);
    add(0,1,ACT,0,1,'h5,    0,1,S_I,-1,0,1);
    for (int i = 0; i < 4; i++) add(0,1,NOP,0,0,0,1,2,S_AG,'hABC,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AG,'hABC,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_AC,'hABC,0,0);
    add(0,0,WR,1,2,0,       1,2,S_WR,'hABC,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_WR,'hABC,0,0);
    add(1,0,WR,1,2,0,       1,2,S_I,0,0,0);
    add(0,0,NOP,0,0,0,      1,2,S_I,0,0,0);
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].stl, tbl[k].cmd, tbl[k].g, tbl[k].b, tbl[k].addr);
      wg = gmap(tbl[k].wg);
      check($sformatf("vec%0d state", k), 32'(fsm[wg][tbl[k].wb]), 32'(tbl[k].est));
      if (tbl[k].erow >= 0) check($sformatf("vec%0d row", k), 32'(row[wg][tbl[k].wb]), tbl[k].erow);
      check($sformatf("vec%0d sync", k), 32'(sync[wg][tbl[k].wb]), 32'(tbl[k].esync));
      check($sformatf("vec%0d cmd_err", k), 32'(cmd_err), 32'(tbl[k].eerr));
    end
    for (int i = 0; i < 4000; i++) begin
      p = $urandom_range(0, 99);
      c = p < 30 ? ACT : p < 45 ? RD : p < 60 ? WR : p < 70 ? PRE : p < 78 ? OTH : NOP;
      step($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 8, c,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, (1 << AW) - 1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
